// File: rtl/game_pkg.sv
// Shared game-control types and default frame timing constants.
// Used by the life controller and by the surrounding game control.
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ALIVE   = 3'd1,
    ST_DYING   = 3'd2,
    ST_RESPAWN = 3'd3,
    ST_GONE    = 3'd4
  } life_state_t;

  localparam int DEF_DEATH_FRAMES  = 60;
  localparam int DEF_INVULN_FRAMES = 120;
  localparam int DEF_MAX_DEATHS    = 3;
  localparam int DEF_BLINK_SHIFT   = 2;

  localparam int          LIVES_W   = 3;
  localparam logic [2:0]  LIVES_SAT = 3'd7;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/frame_timer.sv
// Frame countdown: clear, load, or decrement-to-zero once per tick.
// One frame latency; never underflows, no backpressure.
module frame_timer #(
  parameter int W = 7
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clr,
  input  logic         i_load,
  input  logic [W-1:0] i_value,
  input  logic         i_tick,
  output logic [W-1:0] o_count,
  output logic [W-1:0] o_count_nxt,
  output logic         o_done
);

  logic [W-1:0] r_count;

  always_comb begin
    o_count_nxt = r_count;
    if (i_clr) begin
      o_count_nxt = '0;
    end else if (i_load) begin
      o_count_nxt = i_value;
    end else if (i_tick && (r_count != '0)) begin
      o_count_nxt = r_count - W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else begin
      r_count <= o_count_nxt;
    end
  end

  assign o_count = r_count;
  assign o_done  = (r_count == '0);

endmodule

// File: rtl/player_life_ctrl.sv
// Player life sequencing: alive -> dying -> respawn/invulnerable -> alive, or game over.
// Events sampled at a frame edge show on the registered outputs right after it; no backpressure.
module player_life_ctrl
  import game_pkg::*;
#(
  parameter int DEATH_FRAMES  = DEF_DEATH_FRAMES,
  parameter int INVULN_FRAMES = DEF_INVULN_FRAMES,
  parameter int MAX_DEATHS    = DEF_MAX_DEATHS,
  parameter int BLINK_SHIFT   = DEF_BLINK_SHIFT
) (
  input  logic         frame_clk,
  input  logic         Reset_n,
  input  logic         start,
  input  logic         play,
  input  logic [1:0]   hit,
  input  logic         fall,
  output logic [2:0]   lives,
  output logic         alive,
  output logic         invuln,
  output logic         blink,
  output logic         death_pulse,
  output logic         respawn_pulse
);

  localparam int CNT_W = $clog2(imax(DEATH_FRAMES, INVULN_FRAMES) + 1);

  life_state_t        r_state, w_state_nxt;
  logic [LIVES_W-1:0] r_lives, w_lives_nxt;
  logic               r_alive, r_invuln, r_blink, r_death_pulse, r_respawn_pulse;
  logic               w_death, w_respawn;
  logic               w_clr, w_load, w_tick;
  logic [CNT_W-1:0]   w_load_val;
  logic [CNT_W-1:0]   w_cnt, w_cnt_nxt;
  logic               w_done;

  frame_timer #(.W(CNT_W)) u_timer (
    .i_clk       (frame_clk),
    .i_rst_n     (Reset_n),
    .i_clr       (w_clr),
    .i_load      (w_load),
    .i_value     (w_load_val),
    .i_tick      (w_tick),
    .o_count     (w_cnt),
    .o_count_nxt (w_cnt_nxt),
    .o_done      (w_done)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_lives_nxt = r_lives;
    w_death     = 1'b0;
    w_respawn   = 1'b0;
    w_clr       = 1'b0;
    w_load      = 1'b0;
    w_load_val  = '0;
    w_tick      = 1'b0;

    if (start) begin
      w_state_nxt = ST_IDLE;
      w_lives_nxt = '0;
      w_clr       = 1'b1;
    end else if (!play) begin
      w_state_nxt = ST_IDLE;
      w_clr       = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_ALIVE;
          w_respawn   = 1'b1;
        end
        ST_ALIVE: begin
          if ((|hit) || fall) begin
            w_death = 1'b1;
          end
        end
        ST_DYING: begin
          if (w_done) begin
            if (r_lives >= LIVES_W'(MAX_DEATHS)) begin
              w_state_nxt = ST_GONE;
            end else begin
              w_state_nxt = ST_RESPAWN;
              w_respawn   = 1'b1;
              w_load      = 1'b1;
              w_load_val  = CNT_W'(INVULN_FRAMES - 1);
            end
          end else begin
            w_tick = 1'b1;
          end
        end
        ST_RESPAWN: begin
          // Invulnerability protects against hits only; falling off screen still kills.
          if (fall) begin
            w_death = 1'b1;
          end else if (w_done) begin
            w_state_nxt = ST_ALIVE;
          end else begin
            w_tick = 1'b1;
          end
        end
        ST_GONE: begin
          w_state_nxt = ST_GONE;
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_clr       = 1'b1;
        end
      endcase

      if (w_death) begin
        w_state_nxt = ST_DYING;
        w_lives_nxt = (r_lives == LIVES_SAT) ? LIVES_SAT : r_lives + LIVES_W'(1);
        w_load      = 1'b1;
        w_load_val  = CNT_W'(DEATH_FRAMES - 1);
      end
    end
  end

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state         <= ST_IDLE;
      r_lives         <= '0;
      r_alive         <= 1'b0;
      r_invuln        <= 1'b0;
      r_blink         <= 1'b0;
      r_death_pulse   <= 1'b0;
      r_respawn_pulse <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_lives         <= w_lives_nxt;
      r_alive         <= (w_state_nxt == ST_ALIVE) || (w_state_nxt == ST_RESPAWN);
      r_invuln        <= (w_state_nxt == ST_RESPAWN);
      r_blink         <= (w_state_nxt == ST_RESPAWN) && w_cnt_nxt[BLINK_SHIFT];
      r_death_pulse   <= w_death;
      r_respawn_pulse <= w_respawn;
    end
  end

  assign lives         = r_lives;
  assign alive         = r_alive;
  assign invuln        = r_invuln;
  assign blink         = r_blink;
  assign death_pulse   = r_death_pulse;
  assign respawn_pulse = r_respawn_pulse;

endmodule
